irq_trap_sequencer: RTL and testbench
=====================================

Name: irq_trap_sequencer

Overview:
- Sequences machine-mode interrupt entry and return for the pipelined core.
- Latches pending sources (timer compare hit, external, software) and arbitrates them by fixed priority against the enable bits.
- Captures the EX-stage PC for mepc, sets mcause, clears/restores the global enable, and drives pipeline flush and PC redirect to the trap vector and back on mret.
- Sits between the CSR/interrupt register block and the fetch/hazard unit.

Parameters:
TRAP_VEC, 32'h0000_0100, handler entry address driven on redirect_pc at trap entry.
CAUSE_EXT, 11, mcause code for external interrupt.
CAUSE_SW, 3, mcause code for software interrupt.
CAUSE_TMR, 7, mcause code for timer interrupt.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset rst, synchronous, active-high
timer_hit  in  1  one-cycle pulse, counter reached compare
irq_ext  in  1  external request level
irq_sw  in  1  software request pulse
mie_global  in  1  global interrupt enable (mstatus.MIE equivalent)
mie_mask  in  3  per-source enable {sw, ext, tmr}
pend_clr_we  in  1  CSR write clearing pending bits
pend_clr_mask  in  3  bits to clear when pend_clr_we
ex_valid  in  1  EX stage holds a valid, non-bubble instruction
pc_ex  in  32  PC of EX instruction
mret_ex  in  1  EX instruction is mret
mepc_in  in  32  current saved mepc from CSR block
pending  out  3  pending register {sw, ext, tmr}
mepc_we  out  1  write pc_ex into mepc
mie_clr  out  1  clear global enable
mie_set  out  1  restore global enable
mcause  out  32  bit31=1, low bits = cause code of last taken interrupt
flush  out  1  kill IF/ID/EX contents
redirect  out  1  load redirect_pc into PC
redirect_pc  out  32  target address
in_handler  out  1  high while a handler runs

Behaviour:
- Reset: state IDLE. pending=0, mcause=0, sel=0, all strobes 0, redirect_pc=0, in_handler=0. Reset mid-sequence aborts with no further strobes.
- Pending, per bit, every cycle: next = (cur & ~(pend_clr_we ? pend_clr_mask : 0)) | set. Set sources: timer_hit→bit0, irq_ext→bit1 (sampled each cycle), irq_sw→bit2. Set wins over a simultaneous clear. Taken bit is cleared at CAPTURE, same set-wins rule.
- take = mie_global & |(pending & mie_mask). Priority ext > sw > tmr.
- IDLE: if take → ARB; mret_ex ignored.
- ARB (1 cycle): latch winner index into sel → CAPTURE.
- CAPTURE:
  - If take=0 (masked/cleared meanwhile) → IDLE, no strobes.
  - Else wait for ex_valid. On ex_valid: mepc_we=1, mie_clr=1, clear pending[sel], mcause<={1,27'b0,code(sel)} → FLUSH.
  - mepc_we and mie_clr are combinational from state & ex_valid, asserted exactly one cycle.
- FLUSH: flush=1 for one cycle → VECTOR.
- VECTOR: redirect=1, redirect_pc=TRAP_VEC, one cycle → HANDLER.
- HANDLER: in_handler=1, no nesting; new requests accumulate in pending. On mret_ex: same cycle flush=1, redirect=1, redirect_pc=mepc_in, mie_set=1 → IDLE.
- A pending, enabled request is re-taken at the earliest 2 cycles after return: IDLE, then ARB.
- Entry latency from first take=1 cycle with ex_valid=1: mepc_we at +2, flush at +3, redirect at +4.
- All strobes are Moore or Mealy-on-state only. flush and redirect are never asserted in IDLE, ARB or HANDLER without mret.

Test Plan:
- Timer only: mie_global=1, mie_mask=3'b001, timer_hit pulse, pc_ex=0x40, ex_valid=1 → mepc_we at cycle+2 with pc_ex 0x40; mcause=0x80000007; flush +3; redirect to 0x100 +4; pending=0.
- Priority: irq_ext and irq_sw set same cycle, mask=3'b111 → mcause=0x8000000B, pending=3'b100 remains; after mret (mepc_in=0x44), redirect to 0x44 with mie_set; sw taken next, mcause=0x80000003.
- Masked: pending=3'b001, mie_global=0 → state stays IDLE, no strobes; raise mie_global → entry proceeds.
- Bubbles: take with ex_valid=0 for 5 cycles → stays CAPTURE, no mepc_we; ex_valid=1 with pc_ex=0x80 → mepc_we; mepc value = 0x80.
- Abort: in CAPTURE, pend_clr_we with mask 3'b001 (timer only) → return IDLE, no flush; simultaneous timer_hit with clear → bit stays 1.
- Reset during FLUSH → next cycle IDLE, all outputs 0, mcause=0.

Source files
------------

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt entry/return sequencer: latches pending sources, arbitrates
// them by fixed priority and drives mepc/mcause capture, pipeline flush and PC redirect.
module irq_trap_sequencer #(
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
   parameter int unsigned CAUSE_EXT = 11,
   parameter int unsigned CAUSE_SW  = 3,
   parameter int unsigned CAUSE_TMR = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        timer_hit,
   input  logic        irq_ext,
   input  logic        irq_sw,
   input  logic        mie_global,
   input  logic [2:0]  mie_mask,
   input  logic        pend_clr_we,
   input  logic [2:0]  pend_clr_mask,
   input  logic        ex_valid,
   input  logic [31:0] pc_ex,
   input  logic        mret_ex,
   input  logic [31:0] mepc_in,
   output logic [2:0]  pending,
   output logic        mepc_we,
   output logic        mie_clr,
   output logic        mie_set,
   output logic [31:0] mcause,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        in_handler
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_CAPTURE,
      S_FLUSH,
      S_VECTOR,
      S_HANDLER
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  sel;
   logic [1:0]  winner;
   logic [2:0]  enabled;
   logic        take;
   logic        fire;
   logic [2:0]  clr_bits;
   logic [2:0]  pending_next;

   // sel indexes pending bits: 0 = timer, 1 = external, 2 = software
   function automatic logic [3:0] cause_code(input logic [1:0] idx);
      case (idx)
         2'd1:    cause_code = 4'(CAUSE_EXT);
         2'd2:    cause_code = 4'(CAUSE_SW);
         default: cause_code = 4'(CAUSE_TMR);
      endcase
   endfunction

   assign enabled = pending & mie_mask;
   assign take    = mie_global & (|enabled);
   assign fire    = (state == S_CAPTURE) & take & ex_valid;

   always_comb begin
      winner = 2'd0;
      if (enabled[1]) begin
         winner = 2'd1;
      end else if (enabled[2]) begin
         winner = 2'd2;
      end
   end

   // New requests are OR-ed in after clearing, so a set always beats a clear.
   assign clr_bits     = (pend_clr_we ? pend_clr_mask : 3'b000) | (fire ? (3'b001 << sel) : 3'b000);
   assign pending_next = (pending & ~clr_bits) | {irq_sw, irq_ext, timer_hit};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pending <= 3'b000;
         sel     <= 2'd0;
         mcause  <= 32'd0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         if (state == S_ARB) begin
            sel <= winner;
         end
         if (fire) begin
            mcause <= {1'b1, 27'd0, cause_code(sel)};
         end
      end
   end

   always_comb begin
      state_next  = state;
      mepc_we     = 1'b0;
      mie_clr     = 1'b0;
      mie_set     = 1'b0;
      flush       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      in_handler  = 1'b0;
      case (state)
         S_IDLE: begin
            if (take) begin
               state_next = S_ARB;
            end
         end
         S_ARB: begin
            state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            // Request withdrawn (masked or cleared) before a valid EX instruction arrived.
            if (!take) begin
               state_next = S_IDLE;
            end else if (ex_valid) begin
               mepc_we    = 1'b1;
               mie_clr    = 1'b1;
               state_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            flush      = 1'b1;
            state_next = S_VECTOR;
         end
         S_VECTOR: begin
            redirect    = 1'b1;
            redirect_pc = TRAP_VEC;
            state_next  = S_HANDLER;
         end
         S_HANDLER: begin
            in_handler = 1'b1;
            if (mret_ex) begin
               flush       = 1'b1;
               redirect    = 1'b1;
               redirect_pc = mepc_in;
               mie_set     = 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Randomized and directed bench for irq_trap_sequencer against a step-table reference model.
module tb_irq_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        timer_hit = 1'b0;
   logic        irq_ext = 1'b0;
   logic        irq_sw = 1'b0;
   logic        mie_global = 1'b0;
   logic [2:0]  mie_mask = 3'b000;
   logic        pend_clr_we = 1'b0;
   logic [2:0]  pend_clr_mask = 3'b000;
   logic        ex_valid = 1'b0;
   logic [31:0] pc_ex = 32'd0;
   logic        mret_ex = 1'b0;
   logic [31:0] mepc_in = 32'd0;
   logic [2:0]  pending;
   logic        mepc_we;
   logic        mie_clr;
   logic        mie_set;
   logic [31:0] mcause;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;

   irq_trap_sequencer dut (
      .clk(clk), .rst(rst), .timer_hit(timer_hit), .irq_ext(irq_ext), .irq_sw(irq_sw),
      .mie_global(mie_global), .mie_mask(mie_mask), .pend_clr_we(pend_clr_we),
      .pend_clr_mask(pend_clr_mask), .ex_valid(ex_valid), .pc_ex(pc_ex), .mret_ex(mret_ex),
      .mepc_in(mepc_in), .pending(pending), .mepc_we(mepc_we), .mie_clr(mie_clr),
      .mie_set(mie_set), .mcause(mcause), .flush(flush), .redirect(redirect),
      .redirect_pc(redirect_pc), .in_handler(in_handler)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: step 0 idle, 1 arbitrate, 2 capture, 3 flush, 4 vector, 5 handler
   int          m_step = 0;
   logic [2:0]  m_pend = 3'b000;
   int          m_sel = 0;
   logic [31:0] m_cause = 32'd0;
   bit          m_known = 1'b0;
   int          prio[3] = '{1, 2, 0};
   logic [31:0] code_tab[3] = '{32'd7, 32'd11, 32'd3};
   logic [31:0] csr_mepc = 32'd0;

   logic [31:0] obs_pend, obs_mepc_we, obs_mie_clr, obs_mie_set, obs_mcause;
   logic [31:0] obs_flush, obs_redirect, obs_rpc, obs_inh;

   task automatic step();
      logic [31:0] e_mepc_we, e_mie_clr, e_mie_set, e_flush, e_redirect, e_rpc, e_inh;
      bit          take, found;
      logic [2:0]  kill, clr, setb, n_pend;
      int          n_step, n_sel;
      logic [31:0] n_cause;
      @(negedge clk);
      obs_pend     = 32'(pending);
      obs_mepc_we  = 32'(mepc_we);
      obs_mie_clr  = 32'(mie_clr);
      obs_mie_set  = 32'(mie_set);
      obs_mcause   = mcause;
      obs_flush    = 32'(flush);
      obs_redirect = 32'(redirect);
      obs_rpc      = redirect_pc;
      obs_inh      = 32'(in_handler);
      take = 1'b0;
      for (int i = 0; i < 3; i++) if (m_pend[i] && mie_mask[i]) take = 1'b1;
      take = take && mie_global;
      e_mepc_we = 0; e_mie_clr = 0; e_mie_set = 0; e_flush = 0; e_redirect = 0; e_rpc = 0; e_inh = 0;
      kill = 3'b000; n_step = m_step; n_sel = m_sel; n_cause = m_cause;
      case (m_step)
         0: if (take) n_step = 1;
         1: begin
            found = 1'b0;
            n_sel = 0;
            for (int k = 0; k < 3; k++) begin
               if (!found && m_pend[prio[k]] && mie_mask[prio[k]]) begin
                  n_sel = prio[k];
                  found = 1'b1;
               end
            end
            n_step = 2;
         end
         2: begin
            if (!take) n_step = 0;
            else if (ex_valid) begin
               e_mepc_we = 1; e_mie_clr = 1;
               kill[m_sel] = 1'b1;
               n_cause = 32'h8000_0000 | code_tab[m_sel];
               n_step = 3;
            end
         end
         3: begin e_flush = 1; n_step = 4; end
         4: begin e_redirect = 1; e_rpc = 32'h0000_0100; n_step = 5; end
         default: begin
            e_inh = 1;
            if (mret_ex) begin
               e_flush = 1; e_redirect = 1; e_rpc = mepc_in; e_mie_set = 1; n_step = 0;
            end
         end
      endcase
      clr    = pend_clr_we ? pend_clr_mask : 3'b000;
      setb   = {irq_sw, irq_ext, timer_hit};
      n_pend = setb | (m_pend & ~clr & ~kill);
      if (m_known) begin
         check_eq("pending", obs_pend, 32'(m_pend));
         check_eq("mepc_we", obs_mepc_we, e_mepc_we);
         check_eq("mie_clr", obs_mie_clr, e_mie_clr);
         check_eq("mie_set", obs_mie_set, e_mie_set);
         check_eq("mcause", obs_mcause, m_cause);
         check_eq("flush", obs_flush, e_flush);
         check_eq("redirect", obs_redirect, e_redirect);
         check_eq("redirect_pc", obs_rpc, e_rpc);
         check_eq("in_handler", obs_inh, e_inh);
      end
      if (rst) begin
         n_step = 0; n_pend = 3'b000; n_sel = 0; n_cause = 32'd0;
      end
      @(posedge clk);
      #1;
      if (rst) m_known = 1'b1;
      m_step = n_step; m_pend = n_pend; m_sel = n_sel; m_cause = n_cause;
      // CSR block emulation reacting to the sequencer's strobes
      if (obs_mepc_we[0] === 1'b1) csr_mepc = pc_ex;
      if (obs_mie_clr[0] === 1'b1) mie_global = 1'b0;
      if (obs_mie_set[0] === 1'b1) mie_global = 1'b1;
      mepc_in = csr_mepc;
   endtask

   task automatic run_until(input int target, input int max_cyc);
      int n = 0;
      while (m_step != target && n < max_cyc) begin
         step();
         n++;
      end
      check_eq("wait_state", 32'(m_step), 32'(target));
   endtask

   task automatic mret_once();
      mret_ex = 1'b1;
      step();
      mret_ex = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check_eq("reset_mcause", mcause, 32'd0);
      check_eq("reset_pending", 32'(pending), 32'd0);

      // Timer only
      mie_global = 1'b1; mie_mask = 3'b001; pc_ex = 32'h40; ex_valid = 1'b1;
      timer_hit = 1'b1;
      step();
      timer_hit = 1'b0;
      run_until(5, 20);
      check_eq("tmr_vector_pc", obs_rpc, 32'h100);
      check_eq("tmr_mcause", mcause, 32'h8000_0007);
      check_eq("tmr_pending", 32'(pending), 32'd0);
      check_eq("tmr_mepc", csr_mepc, 32'h40);
      mret_once();
      check_eq("tmr_ret_pc", obs_rpc, 32'h40);

      // Priority: external beats software, software taken after return
      mie_mask = 3'b111; pc_ex = 32'h44;
      irq_ext = 1'b1; irq_sw = 1'b1;
      step();
      irq_ext = 1'b0; irq_sw = 1'b0;
      run_until(5, 20);
      check_eq("prio_mcause_ext", mcause, 32'h8000_000B);
      check_eq("prio_pending_sw", 32'(pending), 32'h4);
      pc_ex = 32'h60;
      mret_once();
      check_eq("prio_ret_pc", obs_rpc, 32'h44);
      check_eq("prio_ret_mie_set", obs_mie_set, 32'd1);
      run_until(5, 20);
      check_eq("prio_mcause_sw", mcause, 32'h8000_0003);
      mret_once();

      // Masked by global enable, then released
      mie_global = 1'b0; mie_mask = 3'b001;
      timer_hit = 1'b1;
      step();
      timer_hit = 1'b0;
      repeat (4) step();
      check_eq("mask_pending", 32'(pending), 32'h1);
      check_eq("mask_in_handler", obs_inh, 32'd0);
      mie_global = 1'b1;
      run_until(5, 20);
      check_eq("mask_mcause", mcause, 32'h8000_0007);
      mret_once();

      // Bubbles in EX hold the capture
      ex_valid = 1'b0;
      timer_hit = 1'b1;
      step();
      timer_hit = 1'b0;
      run_until(2, 20);
      repeat (5) step();
      check_eq("bub_still_capture", obs_mepc_we, 32'd0);
      ex_valid = 1'b1; pc_ex = 32'h80;
      step();
      check_eq("bub_mepc_we", obs_mepc_we, 32'd1);
      check_eq("bub_mepc", csr_mepc, 32'h80);
      run_until(5, 20);
      mret_once();

      // Abort: request cleared while waiting in capture
      ex_valid = 1'b0;
      timer_hit = 1'b1;
      step();
      timer_hit = 1'b0;
      run_until(2, 20);
      pend_clr_we = 1'b1; pend_clr_mask = 3'b001;
      step();
      pend_clr_we = 1'b0;
      step();
      step();
      check_eq("abort_flush", obs_flush, 32'd0);
      check_eq("abort_pending", 32'(pending), 32'd0);
      mie_global = 1'b0;
      timer_hit = 1'b1; pend_clr_we = 1'b1; pend_clr_mask = 3'b001;
      step();
      timer_hit = 1'b0; pend_clr_we = 1'b0;
      check_eq("set_wins", 32'(pending), 32'h1);
      pend_clr_we = 1'b1; pend_clr_mask = 3'b111;
      step();
      pend_clr_we = 1'b0;

      // Reset while flushing
      mie_global = 1'b1; ex_valid = 1'b1;
      timer_hit = 1'b1;
      step();
      timer_hit = 1'b0;
      run_until(3, 20);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check_eq("rst_flush", obs_flush, 32'd0);
      check_eq("rst_redirect", obs_redirect, 32'd0);
      check_eq("rst_in_handler", obs_inh, 32'd0);
      check_eq("rst_mcause", mcause, 32'd0);

      // Randomized traffic
      for (int c = 0; c < 2500; c++) begin
         timer_hit     = ($urandom_range(0, 7) == 0);
         irq_sw        = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 9) == 0) irq_ext = ~irq_ext;
         if ($urandom_range(0, 31) == 0) mie_mask = 3'($urandom);
         pend_clr_we   = ($urandom_range(0, 11) == 0);
         pend_clr_mask = 3'($urandom);
         ex_valid      = ($urandom_range(0, 3) != 0);
         pc_ex         = $urandom & 32'hFFFF_FFFC;
         mret_ex       = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 39) == 0) mie_global = ~mie_global;
         rst           = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
